// File: rtl/ts4231_pulse_timestamper.sv
// TS4231 envelope timestamper: synchronises the envelope, measures each light pulse
// against a free-running counter and queues {timestamp, width, class} records.
module ts4231_pulse_timestamper #(
  parameter int unsigned MIN_WIDTH       = 8,
  parameter int unsigned SWEEP_MAX       = 1200,
  parameter int unsigned MAX_WIDTH       = 16000,
  parameter bit          ENV_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk_96MHz,
  input  logic        reset,
  input  logic        configured,
  input  logic        e_in,
  output logic        pulse_valid,
  input  logic        pulse_ready,
  output logic [31:0] pulse_timestamp,
  output logic [15:0] pulse_width,
  output logic        pulse_is_sweep,
  output logic        overflow,
  output logic        stuck
);

  localparam int unsigned TS_W         = 32;
  localparam int unsigned WID_W        = 16;
  localparam logic        ENV_IDLE_LVL = !ENV_ACTIVE_HIGH;

  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [WID_W-1:0] width;
    logic             is_sweep;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_RISE,
    S_IN_PULSE,
    S_STUCK
  } state_t;

  state_t           state, state_nx;
  logic             sync1, sync2, env, env_d;
  logic [TS_W-1:0]  ts_cnt, ts_reg;
  logic [WID_W-1:0] width;
  logic             ts_load_c, width_inc_c, push_req_c, set_stuck_c;
  logic             push_pend;
  rec_t             push_rec;
  rec_t             mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             pop_c, full_c, do_write_c;
  rec_t             head_c;

  assign env = ENV_ACTIVE_HIGH ? sync2 : ~sync2;

  // Two-flop synchroniser plus one flop of history for edge detection
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      sync1 <= ENV_IDLE_LVL;
      sync2 <= ENV_IDLE_LVL;
      env_d <= 1'b0;
    end else begin
      sync1 <= e_in;
      sync2 <= sync1;
      env_d <= env;
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end

  // Capture FSM; dropping configured aborts whatever is in flight
  always_comb begin
    state_nx    = state;
    ts_load_c   = 1'b0;
    width_inc_c = 1'b0;
    push_req_c  = 1'b0;
    set_stuck_c = 1'b0;
    if (!configured) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nx = S_ARMED;
        S_ARMED: if (!env) state_nx = S_WAIT_RISE;
        S_WAIT_RISE: begin
          if (env && !env_d) begin
            ts_load_c = 1'b1;
            state_nx  = S_IN_PULSE;
          end
        end
        S_IN_PULSE: begin
          if (env) begin
            width_inc_c = 1'b1;
            if (width == WID_W'(MAX_WIDTH - 1)) begin
              set_stuck_c = 1'b1;
              state_nx    = S_STUCK;
            end
          end else begin
            push_req_c = (width >= WID_W'(MIN_WIDTH));
            state_nx   = S_WAIT_RISE;
          end
        end
        S_STUCK: if (!env) state_nx = S_WAIT_RISE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state     <= S_IDLE;
      ts_reg    <= '0;
      width     <= '0;
      stuck     <= 1'b0;
      push_pend <= 1'b0;
      push_rec  <= '0;
    end else begin
      state     <= state_nx;
      push_pend <= push_req_c;
      if (ts_load_c) begin
        ts_reg <= ts_cnt;
        width  <= WID_W'(1);
      end else if (width_inc_c) begin
        width <= width + WID_W'(1);
      end
      if (set_stuck_c) stuck <= 1'b1;
      if (push_req_c) begin
        push_rec.ts       <= ts_reg;
        push_rec.width    <= width;
        push_rec.is_sweep <= (width <= WID_W'(SWEEP_MAX));
      end
    end
  end

  // Two-entry record FIFO; a pop frees the slot for a same-cycle push
  assign pop_c      = pulse_valid && pulse_ready;
  assign full_c     = (count == 2'd2);
  assign do_write_c = push_pend && (!full_c || pop_c);

  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write_c) begin
        mem[wr_ptr] <= push_rec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_c) rd_ptr <= ~rd_ptr;
      if (push_pend && full_c && !pop_c) overflow <= 1'b1;
      case ({do_write_c, pop_c})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_c          = mem[rd_ptr];
  assign pulse_valid     = (count != 2'd0);
  assign pulse_timestamp = head_c.ts;
  assign pulse_width     = head_c.width;
  assign pulse_is_sweep  = head_c.is_sweep;

endmodule

// File: doc/ts4231_pulse_timestamper.md
Name: ts4231_pulse_timestamper

Overview:
- Downstream of the TS4231 configuration stage: consumes the sensor envelope line once the configurator reports `configured`.
- Synchronises and glitch-filters the envelope, then timestamps each light pulse against a free-running 32-bit counter and measures its width.
- Classifies each pulse as sync or sweep and pushes {timestamp, width, class} records into a 2-entry FIFO with a valid/ready output, feeding the lighthouse decoder.

Parameters:
- MIN_WIDTH, 8: minimum synchronised active width, in cycles, for a pulse to be recorded; shorter pulses are discarded as glitches.
- SWEEP_MAX, 1200: widths ≤ SWEEP_MAX are sweep hits; larger widths are sync pulses.
- MAX_WIDTH, 16000: width at which the envelope counts as stuck; must satisfy MAX_WIDTH ≤ 65535 and MAX_WIDTH > SWEEP_MAX.
- ENV_ACTIVE_HIGH, 1: 1 = envelope is active when high; 0 = active when low.

Ports:
- clk_96MHz, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- configured, in, 1: sensor configured; capture is enabled only while this is high.
- e_in, in, 1: raw asynchronous envelope pin.
- pulse_valid, out, 1: FIFO head is valid.
- pulse_ready, in, 1: consumer accepts the head.
- pulse_timestamp, out, 32: counter value at the synchronised active edge.
- pulse_width, out, 16: active cycles.
- pulse_is_sweep, out, 1: 1 = sweep, 0 = sync.
- overflow, out, 1: sticky; a pulse was dropped because the FIFO was full.
- stuck, out, 1: sticky; the envelope was held active for MAX_WIDTH cycles.

Behaviour:
- Reset values:
  - All outputs 0.
  - Timestamp counter 0, FIFO empty, synchroniser flops at the inactive level, FSM in IDLE.
- Input conditioning and timing:
  - e_in passes through 2 flops, then is normalised by ENV_ACTIVE_HIGH to `env` (1 = active).
  - Edge detection uses a third flop.
  - Fixed latency from pin to `env`: 2 cycles. Timestamps carry this constant offset; no compensation.
- Timestamp counter:
  - Free-running, increments every cycle regardless of `configured`.
  - Wraps from 0xFFFFFFFF to 0.
- FSM:
  - IDLE: wait for configured=1, then go to ARMED.
  - ARMED: wait for env=0, then go to WAIT_RISE. This prevents capturing a partial pulse already in progress.
  - WAIT_RISE: on env rising edge, latch the counter into ts_reg, set width=1, go to IN_PULSE.
  - IN_PULSE, while env=1: width increments. When width reaches MAX_WIDTH, set stuck and go to STUCK; no record is made.
  - IN_PULSE, when env falls: if width ≥ MIN_WIDTH, push a record; otherwise discard. Go to WAIT_RISE.
  - STUCK: wait for env=0, then go to WAIT_RISE.
  - Any state, configured=0: go to IDLE next cycle and abort any in-flight pulse. FIFO contents are retained and remain drainable.
- Width rules:
  - Width counts synchronised active cycles exactly: a pulse of N clock periods yields width N.
  - Width is 16 bits and never exceeds MAX_WIDTH.
  - pulse_is_sweep = (width ≤ SWEEP_MAX).
- FIFO:
  - 2 entries, each 49 bits.
  - A push occurs in the cycle after the falling edge is seen; pulse_valid rises the cycle after the push (2 cycles after the `env` fall is observed).
  - Pop occurs when pulse_valid && pulse_ready.
  - Outputs hold stable while pulse_valid=1 and pulse_ready=0.
- FIFO boundary cases:
  - Push while full and no pop in the same cycle: drop the new record, set overflow.
  - Push while full with a pop in the same cycle: both succeed.
  - Push while empty: the record appears at the head and pulse_valid=1 the next cycle.
- Sticky flags: overflow and stuck clear only on reset.
- Reset mid-pulse: everything returns to reset values, and the FSM re-arms through IDLE/ARMED.

Test Plan:
- configured=1, env idle, 100-cycle active pulse starting when counter=0x40 → one record: timestamp 0x42 (2-cycle sync offset), width 100, is_sweep=1.
- 2000-cycle pulse → width 2000, is_sweep=0; a following 5-cycle pulse is discarded, and pulse_valid stays 0 after the first record is popped.
- pulse_ready held 0, three valid pulses → first two records retained in order, third dropped, overflow=1. Then set ready=1 → two pops, valid falls to 0.
- Envelope held active for 20000 cycles → stuck=1 at width 16000, no record pushed. After release, a 50-cycle pulse is recorded normally.
- configured raised while env already active → no record for that pulse; the next full pulse is recorded. configured dropped mid-pulse → pulse aborted, existing FIFO entries still drain.
- Counter preloaded near wrap (force 0xFFFFFFFE) with an edge at wrap → timestamp 0x00000000 or 0xFFFFFFFF exactly per cycle. Reset mid-pulse → all outputs 0 next cycle, counter 0.
